// File: rtl/mul_client_if.sv
// Request, FIFO-pair and result signals of the multiply-engine client.
// master is the client side, slave is the requester/FIFO side.
interface mul_client_if #(
  parameter int RAH_PACKET_WIDTH = 48
);
  logic [RAH_PACKET_WIDTH-1:0]   op_a;
  logic [RAH_PACKET_WIDTH-1:0]   op_b;
  logic                          req_valid;
  logic                          req_ready;
  logic [RAH_PACKET_WIDTH-1:0]   tx_data;
  logic                          tx_wren;
  logic                          tx_full;
  logic [RAH_PACKET_WIDTH-1:0]   rx_data;
  logic                          rx_rden;
  logic                          rx_empty;
  logic [2*RAH_PACKET_WIDTH-1:0] product;
  logic                          product_valid;
  logic                          busy;

  modport master (
    input  op_a, op_b, req_valid, tx_full, rx_data, rx_empty,
    output req_ready, tx_data, tx_wren, rx_rden, product, product_valid, busy
  );

  modport slave (
    output op_a, op_b, req_valid, tx_full, rx_data, rx_empty,
    input  req_ready, tx_data, tx_wren, rx_rden, product, product_valid, busy
  );
endinterface

// File: rtl/mul_client.sv
// Pushes operands A then B to the multiply engine, pops the high then low
// result words and presents the reassembled double-width product.
module mul_client #(
  parameter int RAH_PACKET_WIDTH = 48
) (
  input  logic            clk,
  input  logic            rst,
  mul_client_if.master    bus
);
  localparam int W = RAH_PACKET_WIDTH;

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, HI_REQ, HI_WAIT, HI_CAP, LO_REQ, LO_WAIT, LO_CAP, DONE
  } state_t;

  state_t         state_reg;
  logic [W-1:0]   op_a_reg;
  logic [W-1:0]   op_b_reg;
  logic [W-1:0]   hi_word_reg;
  logic [W-1:0]   tx_data_reg;
  logic           tx_wren_reg;
  logic           rx_rden_reg;
  logic [2*W-1:0] product_reg;
  logic           product_valid_reg;

  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.busy          = (state_reg != IDLE);
  assign bus.tx_data       = tx_data_reg;
  assign bus.tx_wren       = tx_wren_reg;
  assign bus.rx_rden       = rx_rden_reg;
  assign bus.product       = product_reg;
  assign bus.product_valid = product_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      op_a_reg          <= '0;
      op_b_reg          <= '0;
      hi_word_reg       <= '0;
      tx_data_reg       <= '0;
      tx_wren_reg       <= 1'b0;
      rx_rden_reg       <= 1'b0;
      product_reg       <= '0;
      product_valid_reg <= 1'b0;
    end else begin
      // Strobes default low so every write/read/valid is a single-cycle pulse.
      tx_wren_reg       <= 1'b0;
      rx_rden_reg       <= 1'b0;
      product_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_a_reg  <= bus.op_a;
            op_b_reg  <= bus.op_b;
            state_reg <= WR_A;
          end
        end
        WR_A: begin
          if (!bus.tx_full) begin
            tx_data_reg <= op_a_reg;
            tx_wren_reg <= 1'b1;
            state_reg   <= WR_B;
          end
        end
        WR_B: begin
          if (!bus.tx_full) begin
            tx_data_reg <= op_b_reg;
            tx_wren_reg <= 1'b1;
            state_reg   <= HI_REQ;
          end
        end
        HI_REQ: begin
          if (!bus.rx_empty) begin
            rx_rden_reg <= 1'b1;
            state_reg   <= HI_WAIT;
          end
        end
        // rx_data lags the read strobe by one cycle, hence the WAIT states.
        HI_WAIT: state_reg <= HI_CAP;
        HI_CAP: begin
          hi_word_reg <= bus.rx_data;
          state_reg   <= LO_REQ;
        end
        LO_REQ: begin
          if (!bus.rx_empty) begin
            rx_rden_reg <= 1'b1;
            state_reg   <= LO_WAIT;
          end
        end
        LO_WAIT: state_reg <= LO_CAP;
        LO_CAP: begin
          product_reg       <= {hi_word_reg, bus.rx_data};
          product_valid_reg <= 1'b1;
          state_reg         <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_client.sv
// Directed scenario bench for mul_client with a small FIFO-pair model.
`timescale 1ns/1ps
module tb_mul_client;
  localparam int W = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_client_if #(.RAH_PACKET_WIDTH(W)) bus ();
  mul_client #(.RAH_PACKET_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int tx_n = 0, rx_n = 0, pv_n = 0, proto_err = 0;
  logic [W-1:0]   tx_log   [0:63];
  logic [2*W-1:0] prod_log [0:15];
  logic [W-1:0]   rx_words [0:3];
  int   rx_avail = 0, rx_idx = 0, rx_gen = 0;
  logic rx_stall = 1'b0;

  always_comb bus.rx_empty = rx_stall || (rx_idx >= rx_avail);

  // Observes strobes on the falling edge and models the output FIFO read latency.
  initial begin : monitor
    int   seen_gen;
    logic prev_full, prev_rden;
    seen_gen = 0; prev_full = 1'b0; prev_rden = 1'b0;
    bus.rx_data = '0;
    forever begin
      @(negedge clk);
      if (rx_gen != seen_gen) begin
        seen_gen = rx_gen;
        rx_idx   = 0;
      end
      if (bus.tx_wren) begin
        if (prev_full) proto_err++;
        tx_log[tx_n[5:0]] = bus.tx_data;
        tx_n++;
      end
      if (bus.rx_rden) begin
        if (prev_rden || rx_idx >= rx_avail) proto_err++;
        else begin
          bus.rx_data = rx_words[rx_idx];
          rx_idx++;
        end
        rx_n++;
      end
      if (bus.product_valid) begin
        prod_log[pv_n[3:0]] = bus.product;
        pv_n++;
      end
      prev_full = bus.tx_full;
      prev_rden = bus.rx_rden;
    end
  end

  function automatic logic [W-1:0] txl(input int i);
    return tx_log[i[5:0]];
  endfunction

  function automatic logic [2*W-1:0] prl(input int i);
    return prod_log[i[3:0]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rx(input logic [W-1:0] w0, w1, w2, w3, input int n);
    rx_words[0] = w0; rx_words[1] = w1; rx_words[2] = w2; rx_words[3] = w3;
    rx_avail = n;
    rx_gen++;
  endtask

  task automatic start_txn(input logic [W-1:0] a, b);
    bus.op_a = a;
    bus.op_b = b;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_pv(output int cyc);
    cyc = 0;
    while (!bus.product_valid && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.tx_full = 1'b0;
    tick(); tick();
    tests++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    tests++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    tests++; if (bus.tx_wren !== 1'b0 || bus.rx_rden !== 1'b0) begin failures++; $display("FAIL reset_strobes got wren=%0b rden=%0b want 0 0", bus.tx_wren, bus.rx_rden); end
    tests++; if (bus.product !== '0 || bus.product_valid !== 1'b0) begin failures++; $display("FAIL reset_product got %h/%0b want 0/0", bus.product, bus.product_valid); end
    rst = 1'b0;
    tick(); tick();
    tests++; if (bus.req_ready !== 1'b1 || bus.tx_wren !== 1'b0) begin failures++; $display("FAIL reset_idle_after got ready=%0b wren=%0b want 1 0", bus.req_ready, bus.tx_wren); end
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    int t0, r0, p0, e0, cyc;
    t0 = tx_n; r0 = rx_n; p0 = pv_n; e0 = proto_err;
    load_rx(48'h0, 48'hF, 48'h0, 48'h0, 2);
    start_txn(48'd3, 48'd5);
    wait_pv(cyc);
    tests++; if (bus.product_valid !== 1'b1) begin failures++; $display("FAIL basic_pv got %0b want 1", bus.product_valid); end
    tests++; if (cyc !== 8) begin failures++; $display("FAIL basic_latency got %0d want 8", cyc); end
    tests++; if (bus.product !== 96'd15) begin failures++; $display("FAIL basic_product got %h want %h", bus.product, 96'd15); end
    tick();
    tests++; if (bus.product_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL basic_after got pv=%0b ready=%0b want 0 1", bus.product_valid, bus.req_ready); end
    tests++; if (bus.product !== 96'd15) begin failures++; $display("FAIL basic_hold got %h want %h", bus.product, 96'd15); end
    tests++; if (tx_n - t0 !== 2 || txl(t0) !== 48'd3 || txl(t0 + 1) !== 48'd5) begin failures++; $display("FAIL basic_tx got n=%0d %h %h want 2 3 5", tx_n - t0, txl(t0), txl(t0 + 1)); end
    tests++; if (rx_n - r0 !== 2 || pv_n - p0 !== 1 || proto_err !== e0) begin failures++; $display("FAIL basic_counts got rx=%0d pv=%0d err=%0d want 2 1 0", rx_n - r0, pv_n - p0, proto_err - e0); end
    $display("[TB] basic A=3 B=5 product=%h", bus.product);
  endtask

  task automatic test_max();
    int t0, cyc;
    t0 = tx_n;
    load_rx(48'hFFFF_FFFF_FFFE, 48'h0000_0000_0001, 48'h0, 48'h0, 2);
    start_txn(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    wait_pv(cyc);
    tests++; if (bus.product_valid !== 1'b1 || bus.product !== 96'hFFFF_FFFF_FFFE_0000_0000_0001) begin failures++; $display("FAIL max_product got %h/%0b want fffffffffffe000000000001/1", bus.product, bus.product_valid); end
    tick();
    tests++; if (tx_n - t0 !== 2 || txl(t0) !== 48'hFFFF_FFFF_FFFF || txl(t0 + 1) !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL max_tx got n=%0d %h %h want 2 ffffffffffff ffffffffffff", tx_n - t0, txl(t0), txl(t0 + 1)); end
    $display("[TB] max operands product=%h", bus.product);
  endtask

  task automatic test_tx_full();
    int t0, e0, cyc, wr_seen;
    t0 = tx_n; e0 = proto_err; wr_seen = 0;
    load_rx(48'h1, 48'h2, 48'h0, 48'h0, 2);
    bus.tx_full = 1'b1;
    start_txn(48'h123, 48'h456);
    repeat (4) begin tick(); if (bus.tx_wren) wr_seen++; end
    tests++; if (wr_seen !== 0) begin failures++; $display("FAIL full_a_hold got %0d writes want 0", wr_seen); end
    bus.tx_full = 1'b0;
    tick();
    tests++; if (bus.tx_wren !== 1'b1 || bus.tx_data !== 48'h123) begin failures++; $display("FAIL full_a_write got %0b/%h want 1/123", bus.tx_wren, bus.tx_data); end
    bus.tx_full = 1'b1;
    repeat (2) begin tick(); if (bus.tx_wren) wr_seen++; end
    tests++; if (wr_seen !== 0) begin failures++; $display("FAIL full_b_hold got %0d writes want 0", wr_seen); end
    bus.tx_full = 1'b0;
    tick();
    tests++; if (bus.tx_wren !== 1'b1 || bus.tx_data !== 48'h456) begin failures++; $display("FAIL full_b_write got %0b/%h want 1/456", bus.tx_wren, bus.tx_data); end
    wait_pv(cyc);
    tests++; if (bus.product_valid !== 1'b1 || bus.product !== {48'h1, 48'h2}) begin failures++; $display("FAIL full_product got %h want %h", bus.product, {48'h1, 48'h2}); end
    tick();
    tests++; if (tx_n - t0 !== 2 || txl(t0) !== 48'h123 || txl(t0 + 1) !== 48'h456 || proto_err !== e0) begin failures++; $display("FAIL full_tx got n=%0d %h %h err=%0d want 2 123 456 0", tx_n - t0, txl(t0), txl(t0 + 1), proto_err - e0); end
    $display("[TB] tx_full stalls writes=%0d", tx_n - t0);
  endtask

  task automatic test_rx_empty();
    int r0, e0, cyc, seen;
    r0 = rx_n; e0 = proto_err; seen = 0;
    load_rx(48'hABC, 48'hDEF, 48'h0, 48'h0, 2);
    rx_stall = 1'b1;
    start_txn(48'd11, 48'd12);
    repeat (20) begin tick(); if (bus.rx_rden) seen++; end
    tests++; if (seen !== 0 || bus.busy !== 1'b1) begin failures++; $display("FAIL empty_hi_hold got rden=%0d busy=%0b want 0 1", seen, bus.busy); end
    rx_stall = 1'b0;
    cyc = 0;
    while (!bus.rx_rden && cyc < 50) begin tick(); cyc++; end
    tests++; if (bus.rx_rden !== 1'b1) begin failures++; $display("FAIL empty_hi_read got %0b want 1", bus.rx_rden); end
    rx_stall = 1'b1;
    tick();
    tests++; if (bus.rx_rden !== 1'b0) begin failures++; $display("FAIL empty_hi_pulse got %0b want 0", bus.rx_rden); end
    repeat (5) begin tick(); if (bus.rx_rden) seen++; end
    tests++; if (seen !== 0) begin failures++; $display("FAIL empty_lo_hold got %0d reads want 0", seen); end
    rx_stall = 1'b0;
    wait_pv(cyc);
    tests++; if (bus.product_valid !== 1'b1 || bus.product !== {48'hABC, 48'hDEF}) begin failures++; $display("FAIL empty_product got %h want %h", bus.product, {48'hABC, 48'hDEF}); end
    tick();
    tests++; if (rx_n - r0 !== 2 || proto_err !== e0) begin failures++; $display("FAIL empty_reads got %0d err=%0d want 2 0", rx_n - r0, proto_err - e0); end
    $display("[TB] rx_empty stalls product=%h", bus.product);
  endtask

  task automatic test_async_reset();
    int t0, p0, cyc;
    load_rx(48'h111, 48'h222, 48'h0, 48'h0, 2);
    start_txn(48'd9, 48'd10);
    cyc = 0;
    while (!bus.rx_rden && cyc < 50) begin tick(); cyc++; end
    tests++; if (bus.rx_rden !== 1'b1) begin failures++; $display("FAIL arst_reach_wait got %0b want 1", bus.rx_rden); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.rx_rden !== 1'b0 || bus.tx_wren !== 1'b0 || bus.product_valid !== 1'b0) begin failures++; $display("FAIL arst_strobes got rden=%0b wren=%0b pv=%0b want 0 0 0", bus.rx_rden, bus.tx_wren, bus.product_valid); end
    tests++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL arst_ready got ready=%0b busy=%0b want 1 0", bus.req_ready, bus.busy); end
    tests++; if (bus.product !== '0) begin failures++; $display("FAIL arst_product got %h want 0", bus.product); end
    p0 = pv_n;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    tests++; if (pv_n !== p0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL arst_abandon got pv=%0d ready=%0b want 0 1", pv_n - p0, bus.req_ready); end
    t0 = tx_n;
    load_rx(48'h0, 48'd42, 48'h0, 48'h0, 2);
    start_txn(48'd7, 48'd6);
    wait_pv(cyc);
    tests++; if (bus.product_valid !== 1'b1 || bus.product !== 96'd42) begin failures++; $display("FAIL arst_next_product got %h want %h", bus.product, 96'd42); end
    tick();
    tests++; if (tx_n - t0 !== 2 || txl(t0) !== 48'd7 || txl(t0 + 1) !== 48'd6) begin failures++; $display("FAIL arst_next_tx got n=%0d %h %h want 2 7 6", tx_n - t0, txl(t0), txl(t0 + 1)); end
    $display("[TB] async reset then product=%h", bus.product);
  endtask

  task automatic test_back_to_back();
    int t0, r0, p0, e0, cyc, accepts, pvs;
    logic prev_busy;
    t0 = tx_n; r0 = rx_n; p0 = pv_n; e0 = proto_err;
    accepts = 0; pvs = 0; cyc = 0;
    load_rx(48'h1, 48'h200, 48'h2, 48'h201, 4);
    bus.op_a = 48'h10; bus.op_b = 48'h20; bus.req_valid = 1'b1;
    prev_busy = bus.busy;
    while (pvs < 2 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.busy && !prev_busy) begin
        accepts++;
        if (accepts == 1) begin bus.op_a = 48'h30; bus.op_b = 48'h40; end
        else begin bus.op_a = 48'hBAD; bus.op_b = 48'hBAD; end
      end
      if (bus.product_valid) pvs++;
      if (accepts >= 2 && bus.busy) bus.req_valid = ~bus.req_valid;
      prev_busy = bus.busy;
    end
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    tests++; if (accepts !== 2 || pvs !== 2) begin failures++; $display("FAIL b2b_accepts got acc=%0d pv=%0d want 2 2", accepts, pvs); end
    tests++; if (tx_n - t0 !== 4 || txl(t0) !== 48'h10 || txl(t0 + 1) !== 48'h20 || txl(t0 + 2) !== 48'h30 || txl(t0 + 3) !== 48'h40) begin failures++; $display("FAIL b2b_tx got n=%0d %h %h %h %h want 4 10 20 30 40", tx_n - t0, txl(t0), txl(t0 + 1), txl(t0 + 2), txl(t0 + 3)); end
    tests++; if (prl(p0) !== {48'h1, 48'h200} || prl(p0 + 1) !== {48'h2, 48'h201}) begin failures++; $display("FAIL b2b_products got %h %h want %h %h", prl(p0), prl(p0 + 1), {48'h1, 48'h200}, {48'h2, 48'h201}); end
    tests++; if (rx_n - r0 !== 4 || proto_err !== e0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got rx=%0d err=%0d ready=%0b want 4 0 1", rx_n - r0, proto_err - e0, bus.req_ready); end
    $display("[TB] back-to-back accepts=%0d products=%0d", accepts, pvs);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_tx_full();
    test_rx_empty();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
